// File: rtl/music_sequencer.sv
// music_sequencer: steps through a registered note ROM at a fixed beat rate,
// drives the player's note code and lets a held keyboard key override it.
module music_sequencer #(
    parameter int TICK_DIV = 6_250_000,
    parameter int SONG_LEN = 138,
    parameter int ADDR_W   = 8
) (
    input  logic              ext_clk_25m,
    input  logic              ext_rst_n,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              pause_tgl,
    input  logic              loop_en,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        audio_code,
    output logic              busy,
    output logic              song_done
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_PAUSE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_note;
    logic [TICK_W-1:0]   r_tick;
    logic                r_pause_pend;
    logic [3:0]          r_audio;
    logic                r_song_done;

    logic                w_load_pause;
    logic                w_advance;
    logic                w_last_note;
    logic                w_song_end;
    logic [3:0]          w_audio_d;
    logic                w_busy;

    // A pause requested during FETCH/LOAD is applied when LOAD hands over.
    assign w_load_pause = r_pause_pend ^ pause_tgl;
    // End of a beat: a pause or a held key both hold the current tick.
    assign w_advance    = (r_state == S_PLAY) && !pause_tgl && !key_valid &&
                          (r_tick == TICK_LAST);
    assign w_last_note  = !(r_addr < ADDR_LAST);
    assign w_song_end   = w_advance && w_last_note && !loop_en && !play_stop;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state decode; a stop overrides every other event.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (play_start) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = w_load_pause ? S_PAUSE : S_PLAY;
            S_PLAY: begin
                if (pause_tgl)                        w_next = S_PAUSE;
                else if (w_advance && !w_last_note)   w_next = S_FETCH;
                else if (w_advance && loop_en)        w_next = S_FETCH;
                else if (w_advance)                   w_next = S_IDLE;
            end
            S_PAUSE: if (pause_tgl) w_next = S_PLAY;
            default: w_next = S_IDLE;
        endcase
        if (play_stop) w_next = S_IDLE;
    end

    // Output decode: keyboard first, silence when idle or paused, else the note.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_audio_d = r_note;
        if (key_valid)
            w_audio_d = key_code;
        else if (r_state == S_IDLE || r_state == S_PAUSE)
            w_audio_d = 4'd0;
    end

    // Song datapath: address, note, beat counter and pending pause.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_addr       <= '0;
            r_note       <= '0;
            r_tick       <= '0;
            r_pause_pend <= 1'b0;
        end else if (play_stop && r_state != S_IDLE) begin
            r_addr       <= '0;
            r_note       <= '0;
            r_tick       <= '0;
            r_pause_pend <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (pause_tgl) r_pause_pend <= ~r_pause_pend;
                S_LOAD: begin
                    r_note       <= rom_data;
                    r_tick       <= '0;
                    r_pause_pend <= 1'b0;
                end
                S_PLAY: begin
                    if (w_advance) begin
                        r_tick <= '0;
                        if (!w_last_note) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end else begin
                            r_addr <= '0;
                            if (!loop_en) r_note <= '0;
                        end
                    end else if (!pause_tgl && !key_valid) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs so the note changes cleanly on a clock edge.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_audio     <= 4'd0;
            r_song_done <= 1'b0;
        end else begin
            r_audio     <= w_audio_d;
            r_song_done <= w_song_end;
        end
    end

    assign rom_addr   = r_addr;
    assign audio_code = r_audio;
    assign busy       = w_busy;
    assign song_done  = r_song_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with TICK_DIV=4, SONG_LEN=3, ROM={5,1,7}.
module tb_music_sequencer;

    localparam int TICK_DIV = 4;
    localparam int SONG_LEN = 3;
    localparam int ADDR_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              play_start;
    logic              play_stop;
    logic              pause_tgl;
    logic              loop_en;
    logic              key_valid;
    logic [3:0]        key_code;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        audio_code;
    logic              busy;
    logic              song_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int base;

    logic [3:0] rom_tbl [0:2];

    music_sequencer #(
        .TICK_DIV (TICK_DIV),
        .SONG_LEN (SONG_LEN),
        .ADDR_W   (ADDR_W)
    ) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .play_start  (play_start),
        .play_stop   (play_stop),
        .pause_tgl   (pause_tgl),
        .loop_en     (loop_en),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .audio_code  (audio_code),
        .busy        (busy),
        .song_done   (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_addr < 8'(SONG_LEN)) rom_data <= rom_tbl[rom_addr[1:0]];
        else                         rom_data <= 4'd0;
    end

    // Count song_done pulses away from the active edge.
    always @(negedge clk) if (song_done) done_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song();
        play_start = 1'b1;
        step();
        play_start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_tgl = 1'b1;
        step();
        pause_tgl = 1'b0;
    endtask

    // Check audio_code for n consecutive cycles, stepping after each.
    task automatic expect_run(input string tag, input int code, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, int'(audio_code), code);
            step();
        end
    endtask

    // At the last cycle of the final note: done pulse, idle, then silence.
    task automatic expect_end(input string tag);
        check({tag, "_last"}, int'(audio_code), 7);
        check({tag, "_done"}, int'(song_done), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_addr"}, int'(rom_addr), 0);
        step();
        check({tag, "_rest"}, int'(audio_code), 0);
        check({tag, "_done_off"}, int'(song_done), 0);
    endtask

    initial begin
        rom_tbl[0] = 4'd5;
        rom_tbl[1] = 4'd1;
        rom_tbl[2] = 4'd7;
        rst_n = 1'b0; play_start = 1'b0; play_stop = 1'b0; pause_tgl = 1'b0;
        loop_en = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check("rst_addr", int'(rom_addr), 0);
        check("rst_audio", int'(audio_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(song_done), 0);

        // Basic play: 5 and 1 for six cycles each, 7 until song end.
        start_song();
        check("basic_busy", int'(busy), 1);
        check("basic_fetch_addr", int'(rom_addr), 0);
        check("basic_fetch_audio", int'(audio_code), 0);
        repeat (3) step();
        expect_run("basic_n0", 5, 6);
        check("basic_addr1", int'(rom_addr), 1);
        expect_run("basic_n1", 1, 6);
        expect_run("basic_n2", 7, 3);
        expect_end("basic");
        check("basic_done_cnt", done_cnt, 1);

        // Loop: two passes, loop_en dropped during note 1 of pass two.
        loop_en = 1'b1;
        base = done_cnt;
        start_song();
        repeat (3) step();
        expect_run("loop_p1n0", 5, 6);
        expect_run("loop_p1n1", 1, 6);
        expect_run("loop_p1n2", 7, 6);
        expect_run("loop_p2n0", 5, 6);
        check("loop_no_done", done_cnt, base);
        expect_run("loop_p2n1a", 1, 2);
        loop_en = 1'b0;
        expect_run("loop_p2n1b", 1, 4);
        expect_run("loop_p2n2", 7, 3);
        expect_end("loop");

        // Keyboard override during note 1 at tick 2, ten cycles.
        start_song();
        repeat (3) step();
        expect_run("key_n0", 5, 6);
        expect_run("key_n1_pre", 1, 1);
        key_code  = 4'd3;
        key_valid = 1'b1;
        expect_run("key_lag", 1, 1);
        expect_run("key_held", 3, 9);
        key_valid = 1'b0;
        expect_run("key_release_lag", 3, 1);
        expect_run("key_n1_resume", 1, 4);
        expect_run("key_n2", 7, 3);
        expect_end("key");

        // Pause at tick 1 of note 1, resume for the remaining three ticks.
        start_song();
        repeat (3) step();
        expect_run("pause_n0", 5, 6);
        check("pause_pre", int'(audio_code), 1);
        pulse_pause();
        check("pause_lag", int'(audio_code), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            check("pause_audio", int'(audio_code), 0);
            check("pause_addr", int'(rom_addr), 1);
            check("pause_busy", int'(busy), 1);
            if (i < 3) step();
        end
        pulse_pause();
        check("pause_resume_lag", int'(audio_code), 0);
        step();
        expect_run("pause_n1_resume", 1, 5);
        expect_run("pause_n2", 7, 3);
        expect_end("pause");

        // Stop together with pause mid-song: idle, address cleared, no done.
        base = done_cnt;
        start_song();
        repeat (3) step();
        expect_run("stop_n0", 5, 6);
        check("stop_addr_pre", int'(rom_addr), 1);
        play_stop = 1'b1;
        pause_tgl = 1'b1;
        step();
        play_stop = 1'b0;
        pause_tgl = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_addr", int'(rom_addr), 0);
        check("stop_done", int'(song_done), 0);
        step();
        check("stop_audio", int'(audio_code), 0);
        check("stop_done_cnt", done_cnt, base);

        // Start while busy is ignored: timing is unchanged.
        start_song();
        repeat (3) step();
        check("busy_start_n0", int'(audio_code), 5);
        start_song();
        expect_run("busy_start_n0b", 5, 5);
        expect_run("busy_start_n1", 1, 6);
        expect_run("busy_start_n2", 7, 3);
        expect_end("busy_start");

        // Start together with stop in idle: stays idle.
        play_start = 1'b1;
        play_stop  = 1'b1;
        step();
        play_start = 1'b0;
        play_stop  = 1'b0;
        check("collide_busy", int'(busy), 0);
        step();
        check("collide_busy2", int'(busy), 0);
        check("collide_audio", int'(audio_code), 0);

        // Asynchronous reset mid-play, then replay from address 0.
        start_song();
        repeat (3) step();
        expect_run("arst_n0", 5, 6);
        check("arst_pre_addr", int'(rom_addr), 1);
        rst_n = 1'b0;
        #1;
        check("arst_addr", int'(rom_addr), 0);
        check("arst_audio", int'(audio_code), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(song_done), 0);
        step();
        rst_n = 1'b1;
        step();
        start_song();
        check("arst_fetch_addr", int'(rom_addr), 0);
        repeat (3) step();
        expect_run("arst_n0b", 5, 6);
        expect_run("arst_n1", 1, 6);
        expect_run("arst_n2", 7, 3);
        expect_end("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
